// File: rtl/fold_fir_seq.sv
// Folded single-MAC FIR sequencer: accepts a sample, walks taps, times accumulator strobes.
// Optional linear-phase folding is enabled with the SYMMETRIC_FOLD_EN macro.
module fold_fir_seq #(
    parameter int NTAPS   = 24,
    parameter int CNT_W   = 6,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_addr,
    output logic [CNT_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_addr_b,
    output logic [CNT_W-1:0] tap_cnt,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_valid,
    output logic             busy
);

`ifdef SYMMETRIC_FOLD_EN
    localparam int RUN_LEN = NTAPS / 2;
`else
    localparam int RUN_LEN = NTAPS;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0] LAST_TAP   = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(MAC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_head;
    logic [CNT_W-1:0]   r_rd_addr;
    logic [CNT_W-1:0]   r_tap_cnt;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic               r_out_valid;
    logic               r_busy;
    logic [MAC_LAT-1:0] r_vld_pipe;
    logic [MAC_LAT-1:0] r_first_pipe;

    logic w_accept;
    logic w_run;
    logic w_first;

    // Modular step without assuming NTAPS is a power of two.
    function automatic logic [CNT_W-1:0] mod_inc(input logic [CNT_W-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] mod_dec(input logic [CNT_W-1:0] x);
        return (x == '0) ? LAST_IDX : x - 1'b1;
    endfunction

    assign in_ready = rst_n && (r_state == S_IDLE);
    assign wr_en    = in_valid & in_ready;
    assign w_accept = wr_en;
    assign w_run    = (r_state == S_RUN);
    assign w_first  = w_run && (r_tap_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_rd_addr   <= '0;
            r_tap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_head    <= mod_inc(r_head);
                        r_rd_addr <= r_head;
                        r_tap_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_tap_cnt == LAST_TAP) begin
                        r_tap_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_tap_cnt <= r_tap_cnt + 1'b1;
                        r_rd_addr <= mod_dec(r_rd_addr);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == LAST_DRAIN) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SYMMETRIC_FOLD_EN
    logic [CNT_W-1:0] r_rd_addr_b;

    // Mirror tap (newest-(NTAPS-1-k)) equals newest+1+k, so it walks upward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_b <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_rd_addr_b <= mod_inc(r_head);
        end else if (w_run && r_tap_cnt != LAST_TAP) begin
            r_rd_addr_b <= mod_inc(r_rd_addr_b);
        end
    end

    assign rd_addr_b = r_rd_addr_b;
`else
    assign rd_addr_b = '0;
`endif

    // Tap-issue markers delayed by the coefficient-mux plus multiplier registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe   <= '0;
            r_first_pipe <= '0;
        end else begin
            r_vld_pipe[0]   <= w_run;
            r_first_pipe[0] <= w_first;
            for (int i = 1; i < MAC_LAT; i++) begin
                r_vld_pipe[i]   <= r_vld_pipe[i-1];
                r_first_pipe[i] <= r_first_pipe[i-1];
            end
        end
    end

    assign wr_addr   = r_head;
    assign rd_addr   = r_rd_addr;
    assign tap_cnt   = r_tap_cnt;
    assign acc_en    = r_vld_pipe[MAC_LAT-1];
    assign acc_clr   = r_first_pipe[MAC_LAT-1];
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fold_fir_seq.sv
// Directed bench for fold_fir_seq: idle, single sample, abort, back-to-back, pulse-in-RUN.
// Honours SYMMETRIC_FOLD_EN in the same way as the design.
module tb_fold_fir_seq;

    localparam int NT = 24;
    localparam int CW = 6;
    localparam int ML = 2;
`ifdef SYMMETRIC_FOLD_EN
    localparam int RL = NT / 2;
`else
    localparam int RL = NT;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic [CW-1:0] rd_addr;
    logic [CW-1:0] rd_addr_b;
    logic [CW-1:0] tap_cnt;
    logic          acc_clr;
    logic          acc_en;
    logic          out_valid;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_head = 0;

    fold_fir_seq #(.NTAPS(NT), .CNT_W(CW), .MAC_LAT(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_addr_b (rd_addr_b),
        .tap_cnt   (tap_cnt),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_idle();
        in_valid = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_wr_en", wr_en, 0);
        check("idle_acc_en", acc_en, 0);
        check("idle_acc_clr", acc_clr, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_wr_addr", wr_addr, exp_head);
        tick();
    endtask

    // Accept one sample at the current cycle (A) and follow it through DONE.
    task automatic do_sample(input bit hold, input int pulse_j, input int abort_j);
        int newest;
        in_valid = 1'b1;
        #1;
        check("accept_in_ready", in_ready, 1);
        check("accept_wr_en", wr_en, 1);
        check("accept_wr_addr", wr_addr, exp_head);
        newest   = exp_head;
        exp_head = (exp_head + 1) % NT;
        $display("sample accepted cyc=%0d newest=%0d hold=%0d pulse=%0d abort=%0d",
                 cyc, newest, hold, pulse_j, abort_j);
        tick();
        for (int j = 1; j <= RL + ML + 1; j++) begin
            in_valid = hold || (j == pulse_j);
            if (j == abort_j) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_acc_en", acc_en, 0);
                check("abort_acc_clr", acc_clr, 0);
                check("abort_out_valid", out_valid, 0);
                check("abort_in_ready", in_ready, 0);
                check("abort_wr_addr", wr_addr, 0);
                check("abort_rd_addr", rd_addr, 0);
                check("abort_tap_cnt", tap_cnt, 0);
                exp_head = 0;
                repeat (3) begin
                    tick();
                    #1;
                    check("abort_hold_out_valid", out_valid, 0);
                    check("abort_hold_busy", busy, 0);
                end
                rst_n = 1'b1;
                #1;
                check("abort_release_in_ready", in_ready, 1);
                tick();
                return;
            end
            #1;
            check("run_wr_en", wr_en, 0);
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            check("run_wr_addr", wr_addr, exp_head);
            if (j <= RL) begin
                check("run_tap_cnt", tap_cnt, j - 1);
                check("run_rd_addr", rd_addr, (newest - (j - 1) + NT) % NT);
`ifdef SYMMETRIC_FOLD_EN
                check("run_rd_addr_b", rd_addr_b, (newest - (NT - 1 - (j - 1)) + NT) % NT);
`else
                check("run_rd_addr_b", rd_addr_b, 0);
`endif
            end
            check("acc_en", acc_en, (j >= 1 + ML) && (j <= RL + ML));
            check("acc_clr", acc_clr, j == 1 + ML);
            check("out_valid", out_valid, j == RL + ML + 1);
            tick();
        end
        in_valid = hold;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_en", acc_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_tap_cnt", tap_cnt, 0);
        rst_n = 1'b1;
        tick();
        cyc = 0;

        check("idle_rd_addr", rd_addr, 0);
        check("idle_rd_addr_b", rd_addr_b, 0);
        check("idle_tap_cnt", tap_cnt, 0);
        repeat (10) check_idle();

        do_sample(1'b0, 0, 0);
        check_idle();

        do_sample(1'b0, 0, 11);
        check_idle();

        for (int s = 0; s < 25; s++) begin
            do_sample(1'b1, 0, 0);
        end
        check("wrap_wr_addr", wr_addr, 1);
        check_idle();

        do_sample(1'b0, 5, 0);
        check_idle();
        check_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
